gray_frame_sequencer: RTL

GRAY_FRAME_SEQUENCER -- requirements
Module: gray_frame_sequencer

---
 rtl/gray_frame_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/gray_frame_sequencer.sv
// -----------------------------------------------------------------------------
// gray_frame_sequencer
//
// Purpose:
//   Sequences one gray frame at a time through a single-port gray BRAM.
//   A frame is opened by i_FRAME_START, PIXELS pixels are streamed in with a
//   valid/ready handshake and written to consecutive BRAM addresses, the Sobel
//   kernel is kicked with a one-cycle start pulse, and while it runs it owns
//   the BRAM read port. When the kernel reports completion the sequencer
//   pulses o_FRAME_DONE, bumps the frame counter and returns to idle.
//
// Ports:
//   i_CLK               single clock, rising edge
//   i_RSTn              synchronous active-low reset
//   i_FRAME_START       one-cycle pulse opening a new frame load
//   i_PIX_VALID         pixel present on i_PIX_DATA
//   i_PIX_DATA          gray pixel
//   o_PIX_READY         pixel accepted when i_PIX_VALID & o_PIX_READY
//   o_START_RDGRAYBRAM  one-cycle start pulse to the Sobel kernel
//   i_DONE_CAL          kernel finished the frame
//   i_RD_ADDRESS        kernel read address
//   i_RD_READ           kernel read strobe
//   o_BRAM_ADDRESS      gray BRAM address (write address or kernel address)
//   o_BRAM_DATA         gray BRAM write data
//   o_BRAM_WRITE        gray BRAM write enable
//   o_BRAM_READ         gray BRAM read enable
//   o_FRAME_DONE        one-cycle pulse, frame fully processed
//   o_FRAME_CNT         completed frames, wraps 0xFFFF -> 0
//   o_ERR_SHORT         sticky: frame restarted before PIXELS pixels loaded
//   o_BUSY              high in every state except IDLE
// -----------------------------------------------------------------------------
module gray_frame_sequencer #(
    parameter int PIXELS = 76800,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    input  logic              i_FRAME_START,
    input  logic              i_PIX_VALID,
    input  logic [DATA_W-1:0] i_PIX_DATA,
    output logic              o_PIX_READY,
    output logic              o_START_RDGRAYBRAM,
    input  logic              i_DONE_CAL,
    input  logic [ADDR_W-1:0] i_RD_ADDRESS,
    input  logic              i_RD_READ,
    output logic [ADDR_W-1:0] o_BRAM_ADDRESS,
    output logic [DATA_W-1:0] o_BRAM_DATA,
    output logic              o_BRAM_WRITE,
    output logic              o_BRAM_READ,
    output logic              o_FRAME_DONE,
    output logic [15:0]       o_FRAME_CNT,
    output logic              o_ERR_SHORT,
    output logic              o_BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_PROCESS = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [ADDR_W-1:0]   pix_cnt_r;
    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic                ready_r;
    logic                start_r;
    logic                done_r;
    logic                busy_r;
    logic                err_short_r;
    logic [15:0]         frame_cnt_r;

    logic                pix_accept_s;
    logic                last_pix_s;
    logic [ADDR_W-1:0]   bram_addr_s;
    logic                bram_read_s;

    // Handshake decode; ready_r is high exactly while the FSM sits in LOAD.
    always_comb begin
        pix_accept_s = 1'b0;
        last_pix_s   = 1'b0;
        if (ready_r && i_PIX_VALID) begin
            pix_accept_s = 1'b1;
        end else begin
            pix_accept_s = 1'b0;
        end
        if (pix_cnt_r == LAST_PIX) begin
            last_pix_s = 1'b1;
        end else begin
            last_pix_s = 1'b0;
        end
    end

    // Frame FSM with all registered outputs; pulses and the write port default low each cycle.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state_r     <= ST_IDLE;
            pix_cnt_r   <= '0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            ready_r     <= 1'b0;
            start_r     <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            err_short_r <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            start_r   <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_FRAME_START) begin
                        state_r   <= ST_LOAD;
                        pix_cnt_r <= '0;
                        ready_r   <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        ready_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // The accepted pixel always lands at the pre-update count,
                    // even when a restart clears the counter in the same cycle.
                    if (pix_accept_s) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= pix_cnt_r;
                        wr_data_r <= i_PIX_DATA;
                    end
                    if (i_FRAME_START) begin
                        pix_cnt_r   <= '0;
                        err_short_r <= 1'b1;
                    end else if (pix_accept_s && last_pix_s) begin
                        state_r   <= ST_START;
                        pix_cnt_r <= '0;
                        ready_r   <= 1'b0;
                        start_r   <= 1'b1;
                    end else if (pix_accept_s) begin
                        pix_cnt_r <= pix_cnt_r + CNT_ONE;
                    end
                end
                ST_START: begin
                    state_r <= ST_PROCESS;
                end
                ST_PROCESS: begin
                    if (i_DONE_CAL) begin
                        state_r     <= ST_DONE;
                        done_r      <= 1'b1;
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pix_cnt_r <= '0;
                    ready_r   <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // BRAM port mux: the kernel drives address/read with zero latency only in PROCESS.
    always_comb begin
        bram_addr_s = wr_addr_r;
        bram_read_s = 1'b0;
        if (state_r == ST_PROCESS) begin
            bram_addr_s = i_RD_ADDRESS;
            bram_read_s = i_RD_READ;
        end else begin
            bram_addr_s = wr_addr_r;
            bram_read_s = 1'b0;
        end
    end

    assign o_PIX_READY        = ready_r;
    assign o_START_RDGRAYBRAM = start_r;
    assign o_BRAM_ADDRESS     = bram_addr_s;
    assign o_BRAM_DATA        = wr_data_r;
    assign o_BRAM_WRITE       = wr_en_r;
    assign o_BRAM_READ        = bram_read_s;
    assign o_FRAME_DONE       = done_r;
    assign o_FRAME_CNT        = frame_cnt_r;
    assign o_ERR_SHORT        = err_short_r;
    assign o_BUSY             = busy_r;

endmodule
